// File: rtl/seq_tx.sv
// seq_tx: serial pattern transmitter, MSB-first with repeats and optional idle gaps
module seq_tx #(
    parameter int   W        = 16,
    parameter int   GAP      = 0,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] pattern,
    input  logic [4:0]   len,
    input  logic [3:0]   reps,
    output logic         x_out,
    output logic         frame,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_FIN} state_t;
    state_t       state_q, state_d;
    logic [W-1:0] pat_q, pat_d;
    logic [3:0]   idx_q, idx_d, lm1_q, lm1_d, rep_q, rep_d, gap_q, gap_d;
    logic [4:0]   eff_len;
    logic         x_d, frame_d, busy_d, done_d;
    assign eff_len = (len > 5'(W)) ? 5'(W) : len;
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        lm1_d   = lm1_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: if (start) begin
                pat_d   = pattern;
                rep_d   = reps;
                lm1_d   = 4'(eff_len - 5'd1);
                idx_d   = 4'(eff_len - 5'd1);
                state_d = (eff_len == 5'd0) ? S_FIN : S_SEND;
            end
            S_SEND: if (idx_q != 4'd0) begin
                idx_d = idx_q - 4'd1;
            end else if (rep_q == 4'd0) begin
                state_d = S_FIN;
            end else begin
                rep_d = rep_q - 4'd1;
                idx_d = lm1_q;
                if (GAP > 0) begin
                    state_d = S_GAP;
                    gap_d   = 4'(GAP - 1);
                end
            end
            S_GAP: begin
                state_d = (gap_q == 4'd0) ? S_SEND : S_GAP;
                gap_d   = (gap_q == 4'd0) ? gap_q : gap_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
        // outputs are derived from the next state so they leave the flops directly
        x_d     = (state_d == S_SEND) ? pat_d[idx_d] : IDLE_LVL;
        frame_d = (state_d == S_SEND);
        busy_d  = (state_d == S_SEND) || (state_d == S_GAP);
        done_d  = (state_d == S_FIN);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            idx_q   <= '0;
            lm1_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            x_out   <= IDLE_LVL;
            frame   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            lm1_q   <= lm1_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            x_out   <= x_d;
            frame   <= frame_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end
endmodule

// File: tb/tb_seq_tx.sv
// tb_seq_tx: two transmitters (GAP=0 and GAP=2) driven in parallel against a per-job
// expected output stream built from the transmission rules.
module tb_seq_tx;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] pattern = '0;
    logic [4:0]  len = '0;
    logic [3:0]  reps = '0;
    logic        x0, f0, b0, d0, x2, f2, b2, d2;
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  tmpq[$];

    always #5 clock = ~clock;

    seq_tx #(.W(16), .GAP(0), .IDLE_LVL(1'b0)) dut0 (
        .clock(clock), .reset(reset), .start(start), .pattern(pattern), .len(len),
        .reps(reps), .x_out(x0), .frame(f0), .busy(b0), .done(d0));
    seq_tx #(.W(16), .GAP(2), .IDLE_LVL(1'b0)) dut2 (
        .clock(clock), .reset(reset), .start(start), .pattern(pattern), .len(len),
        .reps(reps), .x_out(x2), .frame(f2), .busy(b2), .done(d2));

    typedef struct {
        logic        start;
        logic [15:0] pattern;
        logic [4:0]  len;
        logic [3:0]  reps;
        logic [3:0]  exp;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {x,frame,busy,done}=%b expected %b", nm, act, exp);
        end
    endtask

    // expected {x,frame,busy,done} per cycle after the start edge, ending with the done cycle
    function automatic void build(input logic [15:0] p, input int l, input int r, input int g);
        tmpq.delete();
        if (l > 16) l = 16;
        if (l > 0)
            for (int k = 0; k <= r; k++) begin
                for (int i = 0; i < l; i++) tmpq.push_back({p[l-1-i], 3'b110});
                if (k < r) for (int j = 0; j < g; j++) tmpq.push_back(4'b0010);
            end
        tmpq.push_back(4'b0001);
    endfunction

    task automatic job(input logic [15:0] p, input logic [4:0] l, input logic [3:0] r, input bit scr);
        logic [3:0] e0q[$], e2q[$];
        int n0, n2, nmin, nmax;
        build(p, int'(l), int'(r), 0);
        e0q = tmpq;
        build(p, int'(l), int'(r), 2);
        e2q = tmpq;
        n0 = e0q.size();
        n2 = e2q.size();
        nmin = (n0 < n2) ? n0 : n2;
        nmax = (n0 > n2) ? n0 : n2;
        start = 1'b1; pattern = p; len = l; reps = r;
        for (int i = 0; i <= nmax; i++) begin
            @(negedge clock);
            chk($sformatf("job%h/%0d/%0d dut0 cyc%0d", p, l, r, i), {x0, f0, b0, d0}, i < n0 ? e0q[i] : 4'b0000);
            chk($sformatf("job%h/%0d/%0d dut2 cyc%0d", p, l, r, i), {x2, f2, b2, d2}, i < n2 ? e2q[i] : 4'b0000);
            start = (scr && i < nmin) ? 1'($urandom) : 1'b0;
            if (scr) begin
                pattern = 16'($urandom);
                len = 5'($urandom);
                reps = 4'($urandom);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 16'h0002, 5'd2, 4'd0, 4'b1110};
        tbl[1] = '{1'b1, 16'h0002, 5'd2, 4'd0, 4'b0110};
        tbl[2] = '{1'b1, 16'h0002, 5'd2, 4'd0, 4'b0001};
        tbl[3] = '{1'b1, 16'h0002, 5'd2, 4'd0, 4'b0000};
        tbl[4] = '{1'b1, 16'h0002, 5'd2, 4'd0, 4'b1110};
        tbl[5] = '{1'b0, 16'h0002, 5'd2, 4'd0, 4'b0110};
        tbl[6] = '{1'b0, 16'h0002, 5'd2, 4'd0, 4'b0001};
        tbl[7] = '{1'b0, 16'h0002, 5'd2, 4'd0, 4'b0000};
        tbl[8] = '{1'b1, 16'hFFFF, 5'd0, 4'd3, 4'b0001};
        tbl[9] = '{1'b0, 16'hFFFF, 5'd0, 4'd3, 4'b0000};

        #1;
        chk("reset dut0", {x0, f0, b0, d0}, 4'b0000);
        chk("reset dut2", {x2, f2, b2, d2}, 4'b0000);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        job(16'h000D, 5'd6, 4'd2, 1'b0);
        job(16'hA5C3, 5'd20, 4'd0, 1'b0);
        job(16'h0005, 5'd3, 4'd1, 1'b0);
        job(16'h1234, 5'd0, 4'd5, 1'b0);
        job(16'h00B6, 5'd8, 4'd1, 1'b1);

        for (int i = 0; i < 10; i++) begin
            start = tbl[i].start; pattern = tbl[i].pattern; len = tbl[i].len; reps = tbl[i].reps;
            @(negedge clock);
            chk($sformatf("tbl%0d dut0", i), {x0, f0, b0, d0}, tbl[i].exp);
            chk($sformatf("tbl%0d dut2", i), {x2, f2, b2, d2}, tbl[i].exp);
        end
        start = 1'b0;

        start = 1'b1; pattern = 16'h00B6; len = 5'd8; reps = 4'd1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        chk("pre-abort bit3 dut0", {x0, f0, b0, d0}, 4'b0110);
        #2 reset = 1'b1;
        #1;
        chk("async abort dut0", {x0, f0, b0, d0}, 4'b0000);
        chk("async abort dut2", {x2, f2, b2, d2}, 4'b0000);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk($sformatf("post-abort idle%0d dut0", i), {x0, f0, b0, d0}, 4'b0000);
            chk($sformatf("post-abort idle%0d dut2", i), {x2, f2, b2, d2}, 4'b0000);
        end
        job(16'h00B6, 5'd8, 4'd1, 1'b0);

        for (int t = 0; t < 30; t++)
            job(16'($urandom), 5'($urandom_range(0, 20)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_tx.md
# seq_tx

Serial pattern transmitter: the source end of the single-bit serial stream that the sequence detectors consume. On a start request it latches a parallel pattern, a length and a repeat count, then shifts the pattern out MSB-first, one bit per clock, optionally inserting idle gaps between repeats. It replaces hand-timed stimulus forks in system-level benches and feeds `seq_det`-style receivers directly in-system.

## Interface
- `W`, 16: maximum pattern length in bits (2..16)
- `GAP`, 0: idle cycles inserted between consecutive repeats (0..15)
- `IDLE_LVL`, 0: value driven on `x_out` when no bit is being sent
- `clock`  in  1  sole clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `start`  in  1  transmit request, sampled only in IDLE
- `pattern`  in  W  bits to send; bit `len-1` is sent first, bit 0 last
- `len`  in  5  number of bits per transmission; 0 = nothing sent, >W clamped to W
- `reps`  in  4  additional repeats; total transmissions = `reps`+1
- `x_out`  out  1  serial data
- `frame`  out  1  high in every cycle `x_out` carries a pattern bit
- `busy`  out  1  high in SEND and GAP states
- `done`  out  1  one-cycle pulse after the final bit

## Operation
- States: IDLE, SEND, GAP, FIN.
- IDLE: `x_out`=IDLE_LVL, `frame`=0, `busy`=0, `done`=0. On `start`=1 at an edge: latch `pattern`, effective length L=min(`len`,W), repeat counter R=`reps`, bit index=L-1. If L=0 go to FIN; else go to SEND.
- SEND: `x_out`=latched pattern[index], `frame`=1, `busy`=1. Each edge decrements index. At index 0: if R=0 go to FIN; else decrement R, reload index=L-1, and go to GAP if GAP>0, else stay in SEND (back-to-back, no idle bit).
- GAP: `x_out`=IDLE_LVL, `frame`=0, `busy`=1; gap counter runs GAP cycles then returns to SEND.
- FIN: `done`=1, `busy`=0, `frame`=0, `x_out`=IDLE_LVL; unconditionally to IDLE on next edge. `start` in FIN is ignored.
- `start` is ignored in SEND, GAP and FIN; input changes after the latching edge have no effect on the current transmission.
- All outputs are registered (Moore); no combinational path from inputs to outputs.
- Counters: index 4 bits, gap counter 4 bits, R 4 bits; no wrap-around is reachable given clamping.

## Timing
- Reset values: `x_out`=IDLE_LVL, `frame`=0, `busy`=0, `done`=0, state IDLE. Assertion mid-transmission aborts at once, with no `done` pulse; transmission resumes only on a new `start` after release.
- Latency: first bit appears in the cycle immediately after the edge that samples `start`.
- Duration, start edge to `done` cycle: (reps+1)·L + reps·GAP cycles of SEND/GAP, then one FIN cycle.
- L=0: `done` in the cycle after the start edge; `frame` never rises.
- Earliest restart: `start` held high continuously produces a new transmission on the edge after FIN, so consecutive jobs are separated by exactly one IDLE cycle plus one FIN cycle.
- `busy` falls in the same cycle `done` rises.

## Test plan
- `pattern`=6'b001101, `len`=6, `reps`=2, GAP=0 -> `x_out` = 001101001101001101 over 18 consecutive cycles with `frame` high throughout, then `done` for one cycle; a connected `seq_det` fires at the expected positions.
- `pattern`=16'hA5C3, `len`=20 (clamped to 16), `reps`=0 -> `x_out` = 1010010111000011, then `done`.
- `len`=3, `pattern`=3'b101, `reps`=1, GAP=2 -> 1,0,1, idle, idle, 1,0,1, then `done`; `frame`=0 and `busy`=1 during the gap.
- `len`=0, `start` pulse -> `done` one cycle later, `frame` stays 0, `x_out`=IDLE_LVL.
- `reset` asserted between clock edges during bit 3 of an 8-bit send -> all outputs return to reset values before the next edge, no `done`; a new `start` after release sends the full pattern.
- `start` pulsed during SEND, and `pattern` changed mid-send -> ignored; the stream is unchanged and `done` timing matches the original job.
